// File: rtl/timebase_pkg.sv
// Shared constants and elaboration-time helpers for the digital-clock timebase.
// Divider ratios are derived from the board clock and the wanted tick rates;
// the fast-forward divider only matters when TIMEBASE_FAST_EN is defined.
package timebase_pkg;

    // Seconds in one minute; o_sec wraps from SEC_PER_MIN-1 back to zero.
    localparam int SEC_PER_MIN = 32'sd60;

    // Width of the seconds-of-minute output.
    localparam int SEC_W = 32'sd6;

    // Cycles per seconds tick; zero flags an unusable tick rate.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz > 32'sd0) begin
            return clk_hz / tick_hz;
        end else begin
            return 32'sd0;
        end
    endfunction

    // Cycles per display-scan tick; zero flags an unusable scan rate.
    function automatic int calc_scan_div(input int clk_hz, input int scan_hz);
        if (scan_hz > 32'sd0) begin
            return clk_hz / scan_hz;
        end else begin
            return 32'sd0;
        end
    endfunction

    // Cycles per seconds tick while fast-forwarding.
    function automatic int calc_fast_div(input int div, input int fast_mult);
        if (fast_mult > 32'sd0) begin
            return div / fast_mult;
        end else begin
            return 32'sd0;
        end
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 32'sd2) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage : timebase_pkg

// File: rtl/tick_div.sv
// Generic clock-enable divider: o_tick pulses for one cycle every `div`
// enabled cycles. `div` is a runtime value so one counter can serve any
// rate; the >= terminal compare keeps it from overrunning if `div` shrinks
// mid-period.
module tick_div #(
    parameter int W = 4
) (
    input  logic         clk_100Mhz,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         o_tick
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_s;
    logic         tick_s;
    logic         term_s;

    // Next counter value and tick pulse; clear wins over enable.
    always_comb begin
        cnt_s  = cnt_r;
        tick_s = 1'b0;
        term_s = (cnt_r >= (div - W'(1)));
        if (clr) begin
            cnt_s  = '0;
            tick_s = 1'b0;
        end else if (en) begin
            if (term_s) begin
                cnt_s  = '0;
                tick_s = 1'b1;
            end else begin
                cnt_s  = cnt_r + W'(1);
                tick_s = 1'b0;
            end
        end else begin
            cnt_s  = cnt_r;
            tick_s = 1'b0;
        end
    end

    // Counter and registered tick output.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            o_tick <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            o_tick <= tick_s;
        end
    end

endmodule : tick_div

// File: rtl/timebase_gen.sv
// Timebase for the seven-segment clock: seconds tick, 50% seconds square
// wave, seconds-of-minute count with minute tick, and a free-running scan tick.
// Optional feature macro: TIMEBASE_FAST_EN enables the i_fast fast-forward
// divider; without it i_fast is ignored and the seconds period is fixed.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1,
    parameter int SCAN_HZ     = 1000,
    parameter int FAST_MULT   = 60
) (
    input  logic             clk_100Mhz,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_fast,
    input  logic             i_sync_clr,
    output logic             o_tick_1hz,
    output logic             o_clk_1hz,
    output logic [SEC_W-1:0] o_sec,
    output logic             o_min_tick,
    output logic             o_scan_tick
);

    localparam int DIV      = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int SCAN_DIV = calc_scan_div(CLK_FREQ_HZ, SCAN_HZ);
    localparam int FAST_DIV = calc_fast_div(DIV, FAST_MULT);
    localparam int CNT_W    = cnt_width(DIV);
    localparam int SCAN_W   = cnt_width(SCAN_DIV + 32'sd1);

    // Terminal and half-period compare values, stored as "minus one" so they
    // fit the $clog2(DIV)-wide counter even when DIV is a power of two.
    localparam logic [CNT_W-1:0] DIV_LAST       = CNT_W'(DIV - 32'sd1);
    localparam logic [CNT_W-1:0] DIV_HALF_LAST  = CNT_W'((DIV / 32'sd2) - 32'sd1);
    localparam logic [SEC_W-1:0] SEC_LAST       = SEC_W'(SEC_PER_MIN - 32'sd1);

    // Parameter legality, rejected at elaboration.
    if ((DIV % 32'sd2 != 32'sd0) || (DIV < 32'sd2)) begin : g_bad_div
        $error("timebase_gen: DIV must be even and at least 2");
    end
    if (SCAN_DIV < 32'sd2) begin : g_bad_scan_div
        $error("timebase_gen: SCAN_DIV must be at least 2");
    end

`ifdef TIMEBASE_FAST_EN
    localparam logic [CNT_W-1:0] FAST_LAST      = CNT_W'(FAST_DIV - 32'sd1);
    localparam logic [CNT_W-1:0] FAST_HALF_LAST = CNT_W'((FAST_DIV / 32'sd2) - 32'sd1);

    if ((FAST_MULT < 32'sd1) || (DIV % FAST_MULT != 32'sd0)) begin : g_bad_fast_mult
        $error("timebase_gen: DIV must be divisible by FAST_MULT");
    end
    if ((FAST_DIV % 32'sd2 != 32'sd0) || (FAST_DIV < 32'sd2)) begin : g_bad_fast_div
        $error("timebase_gen: FAST_DIV must be even and at least 2");
    end
`endif

    logic [CNT_W-1:0] sec_cnt_r;
    logic [CNT_W-1:0] sec_cnt_s;
    logic             clk_1hz_r;
    logic             clk_1hz_s;
    logic             tick_r;
    logic             tick_s;
    logic             min_tick_r;
    logic             min_tick_s;
    logic [SEC_W-1:0] sec_r;
    logic [SEC_W-1:0] sec_s;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] half_last_s;
    logic             term_s;

`ifdef TIMEBASE_FAST_EN
    // Active period selection; >= lets a switch to the shorter period end
    // the current period on the next edge instead of overrunning.
    always_comb begin
        if (i_fast) begin
            last_s      = FAST_LAST;
            half_last_s = FAST_HALF_LAST;
        end else begin
            last_s      = DIV_LAST;
            half_last_s = DIV_HALF_LAST;
        end
        term_s = (sec_cnt_r >= last_s);
    end
`else
    logic unused_fast_s;
    assign unused_fast_s = i_fast;

    // Fixed period: the counter can never pass DIV-1, so equality suffices.
    always_comb begin
        last_s      = DIV_LAST;
        half_last_s = DIV_HALF_LAST;
        term_s      = (sec_cnt_r == last_s);
    end
`endif

    // Seconds channel next state: clear beats pause beats counting.
    always_comb begin
        sec_cnt_s  = sec_cnt_r;
        clk_1hz_s  = clk_1hz_r;
        tick_s     = 1'b0;
        min_tick_s = 1'b0;
        sec_s      = sec_r;
        if (i_sync_clr) begin
            sec_cnt_s = '0;
            clk_1hz_s = 1'b0;
        end else if (!i_run) begin
            sec_cnt_s = sec_cnt_r;
            clk_1hz_s = clk_1hz_r;
        end else if (term_s) begin
            sec_cnt_s = '0;
            clk_1hz_s = 1'b0;
            tick_s    = 1'b1;
            if (sec_r >= SEC_LAST) begin
                sec_s      = '0;
                min_tick_s = 1'b1;
            end else begin
                sec_s      = sec_r + SEC_W'(1);
                min_tick_s = 1'b0;
            end
        end else begin
            sec_cnt_s = sec_cnt_r + CNT_W'(1);
            if (sec_cnt_r == half_last_s) begin
                clk_1hz_s = 1'b1;
            end else begin
                clk_1hz_s = clk_1hz_r;
            end
        end
    end

    // Seconds channel state and registered outputs.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_r  <= '0;
            clk_1hz_r  <= 1'b0;
            tick_r     <= 1'b0;
            min_tick_r <= 1'b0;
            sec_r      <= '0;
        end else begin
            sec_cnt_r  <= sec_cnt_s;
            clk_1hz_r  <= clk_1hz_s;
            tick_r     <= tick_s;
            min_tick_r <= min_tick_s;
            sec_r      <= sec_s;
        end
    end

    assign o_tick_1hz = tick_r;
    assign o_clk_1hz  = clk_1hz_r;
    assign o_min_tick = min_tick_r;
    assign o_sec      = sec_r;

    // Display scan: free-running, independent of run/fast/clear.
    tick_div #(
        .W (SCAN_W)
    ) u_scan_div (
        .clk_100Mhz (clk_100Mhz),
        .rst_n      (rst_n),
        .en         (1'b1),
        .clr        (1'b0),
        .div        (SCAN_W'(SCAN_DIV)),
        .o_tick     (o_scan_tick)
    );

endmodule : timebase_gen

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen with a small divider set
// (DIV=20, SCAN_DIV=4, FAST_DIV=4). A behavioural model tracks enabled
// cycles per period and is compared against the DUT every cycle.
module tb_timebase_gen;

    localparam int CLK_FREQ_HZ = 20;
    localparam int TICK_HZ     = 1;
    localparam int SCAN_HZ     = 5;
    localparam int FAST_MULT   = 5;
    localparam int M_DIV       = CLK_FREQ_HZ / TICK_HZ;
    localparam int M_SCAN      = CLK_FREQ_HZ / SCAN_HZ;
    localparam int M_FAST      = M_DIV / FAST_MULT;

    logic       clk_100Mhz = 1'b0;
    logic       rst_n      = 1'b0;
    logic       i_run      = 1'b0;
    logic       i_fast     = 1'b0;
    logic       i_sync_clr = 1'b0;
    logic       o_tick_1hz;
    logic       o_clk_1hz;
    logic [5:0] o_sec;
    logic       o_min_tick;
    logic       o_scan_tick;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    // Model state: enabled edges into the current period, and output images.
    int m_ph     = 0;
    int m_sec    = 0;
    int m_clk    = 0;
    int m_tick   = 0;
    int m_min    = 0;
    int m_scan   = 0;
    int m_edges  = 0;

    timebase_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .FAST_MULT   (FAST_MULT)
    ) dut (
        .clk_100Mhz  (clk_100Mhz),
        .rst_n       (rst_n),
        .i_run       (i_run),
        .i_fast      (i_fast),
        .i_sync_clr  (i_sync_clr),
        .o_tick_1hz  (o_tick_1hz),
        .o_clk_1hz   (o_clk_1hz),
        .o_sec       (o_sec),
        .o_min_tick  (o_min_tick),
        .o_scan_tick (o_scan_tick)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = 0;
        m_sec   = 0;
        m_clk   = 0;
        m_tick  = 0;
        m_min   = 0;
        m_scan  = 0;
        m_edges = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step();
        int ad;
        m_edges++;
        m_scan = ((m_edges % M_SCAN) == 0) ? 1 : 0;
`ifdef TIMEBASE_FAST_EN
        ad = i_fast ? M_FAST : M_DIV;
`else
        ad = M_DIV;
`endif
        m_tick = 0;
        m_min  = 0;
        if (i_sync_clr) begin
            m_ph  = 0;
            m_clk = 0;
        end else if (i_run) begin
            if (m_ph + 1 >= ad) begin
                m_ph   = 0;
                m_tick = 1;
                m_clk  = 0;
                m_min  = (m_sec == 59) ? 1 : 0;
                m_sec  = (m_sec + 1) % 60;
            end else begin
                m_ph = m_ph + 1;
                if (m_ph == ad / 2) m_clk = 1;
            end
        end
    endtask

    // Model tracks DUT edges and asynchronous reset.
    initial begin
        forever begin
            @(posedge clk_100Mhz or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison on the inactive clock edge.
    initial begin
        forever begin
            @(negedge clk_100Mhz);
            if (chk_en) begin
                check("cyc_tick", int'(o_tick_1hz), m_tick);
                check("cyc_clk",  int'(o_clk_1hz),  m_clk);
                check("cyc_sec",  int'(o_sec),      m_sec);
                check("cyc_min",  int'(o_min_tick), m_min);
                check("cyc_scan", int'(o_scan_tick), m_scan);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_tick", int'(o_tick_1hz), 0);
        check("arst_clk",  int'(o_clk_1hz),  0);
        check("arst_sec",  int'(o_sec),      0);
        check("arst_min",  int'(o_min_tick), 0);
        check("arst_scan", int'(o_scan_tick), 0);
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        i_run = 1'b1;
        step(3);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rel_tick", int'(o_tick_1hz), 0);
        check("rel_clk",  int'(o_clk_1hz),  0);
        check("rel_sec",  int'(o_sec),      0);
        check("rel_min",  int'(o_min_tick), 0);
        check("rel_scan", int'(o_scan_tick), 0);

        // First period: square rises at edge 10, tick at edge 20.
        step(9);
        check("e9_clk", int'(o_clk_1hz), 0);
        step(1);
        check("e10_clk", int'(o_clk_1hz), 1);
        step(9);
        check("e19_clk", int'(o_clk_1hz), 1);
        check("e19_tick", int'(o_tick_1hz), 0);
        step(1);
        check("e20_tick", int'(o_tick_1hz), 1);
        check("e20_clk", int'(o_clk_1hz), 0);
        check("e20_sec", int'(o_sec), 1);
        check("e20_scan", int'(o_scan_tick), 1);
        step(1);
        check("e21_tick", int'(o_tick_1hz), 0);
        check("e21_scan", int'(o_scan_tick), 0);
        step(19);
        check("e40_tick", int'(o_tick_1hz), 1);
        check("e40_sec", int'(o_sec), 2);
        step(20);
        check("e60_tick", int'(o_tick_1hz), 1);
        check("e60_sec", int'(o_sec), 3);

        // Run to the minute wrap.
        step(1120);
        check("sec59", int'(o_sec), 59);
        check("sec59_min", int'(o_min_tick), 0);
        step(20);
        check("wrap_sec", int'(o_sec), 0);
        check("wrap_min", int'(o_min_tick), 1);
        check("wrap_tick", int'(o_tick_1hz), 1);
        step(1);
        check("post_wrap_min", int'(o_min_tick), 0);

        // Pause 13 cycles at period phase 7.
        step(6);
        i_run = 1'b0;
        step(13);
        check("pause_clk", int'(o_clk_1hz), 0);
        check("pause_tick", int'(o_tick_1hz), 0);
        i_run = 1'b1;
        step(12);
        check("resume_early", int'(o_tick_1hz), 0);
        step(1);
        check("resume_tick", int'(o_tick_1hz), 1);
        check("resume_sec", int'(o_sec), 1);

        // Clear at phase 15 with the square high.
        step(15);
        check("preclr_clk", int'(o_clk_1hz), 1);
        i_sync_clr = 1'b1;
        step(1);
        i_sync_clr = 1'b0;
        check("clr_clk", int'(o_clk_1hz), 0);
        check("clr_sec", int'(o_sec), 1);
        step(19);
        check("clr_early", int'(o_tick_1hz), 0);
        step(1);
        check("clr_tick", int'(o_tick_1hz), 1);
        check("clr_tick_sec", int'(o_sec), 2);

`ifdef TIMEBASE_FAST_EN
        // Fast mode entered at phase 12 ends the period on the next edge.
        step(12);
        i_fast = 1'b1;
        step(1);
        check("fast_first", int'(o_tick_1hz), 1);
        step(3);
        check("fast_mid_tick", int'(o_tick_1hz), 0);
        check("fast_mid_clk", int'(o_clk_1hz), 1);
        step(1);
        check("fast_tick", int'(o_tick_1hz), 1);
        check("fast_tick_clk", int'(o_clk_1hz), 0);
        step(8);
        i_fast = 1'b0;
`endif

        // Asynchronous reset between edges.
        step(5);
        async_reset();

        // Randomised run/pause/clear/fast and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            i_run      = ($urandom_range(0, 99) < 90);
            i_sync_clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) i_fast = ~i_fast;
            if ($urandom_range(0, 999) < 3) async_reset();
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_timebase_gen
